// File: rtl/jk_seq_pkg.sv
// Shared op-codes, FSM encoding and the JK next-state rule for the
// JK bank sequencer.
package jk_seq_pkg;

    localparam logic [2:0] OP_HOLD       = 3'd0;
    localparam logic [2:0] OP_CLEAR      = 3'd1;
    localparam logic [2:0] OP_SET        = 3'd2;
    localparam logic [2:0] OP_TOGGLE     = 3'd3;
    localparam logic [2:0] OP_LOAD       = 3'd4;
    localparam logic [2:0] OP_COUNT_UP   = 3'd5;
    localparam logic [2:0] OP_COUNT_DOWN = 3'd6;
    localparam logic [2:0] OP_RSVD       = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic jk_next(input logic q, input logic j, input logic k);
        logic nxt;
        case ({j, k})
            2'b00:   nxt = q;
            2'b01:   nxt = 1'b0;
            2'b10:   nxt = 1'b1;
            2'b11:   nxt = ~q;
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_cell
    import jk_seq_pkg::*;
(
    input  logic Clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q
);

    logic q_r;

    // JK state register
    always_ff @(posedge Clk) begin
        if (rst) begin
            q_r <= 1'b0;
        end else begin
            q_r <= jk_next(q_r, J, K);
        end
    end

    assign Q = q_r;

endmodule

// File: rtl/jk_bank_seq_ctrl.sv
// Command-driven sequencer that drives J/K of a bank of WIDTH JK cells for a
// programmed number of edges, with valid/ready intake and busy/done status.
module jk_bank_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE_C  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] remaining_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] j_s;
    logic [WIDTH-1:0] k_s;
    logic [WIDTH-1:0] carry_up_s;
    logic [WIDTH-1:0] carry_dn_s;
    logic [WIDTH-1:0] mask_s;

    // Counter carry terms: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        carry_up_s = ZERO_W;
        carry_dn_s = ZERO_W;
        mask_s     = ZERO_W;
        for (int i = 0; i < WIDTH; i++) begin
            mask_s        = (ONE_W << i) - ONE_W;
            carry_up_s[i] = ((q_s & mask_s) == mask_s);
            carry_dn_s[i] = ((~q_s & mask_s) == mask_s);
        end
    end

    // Per-bit J/K from the latched op; cells hold outside RUN
    always_comb begin
        j_s = ZERO_W;
        k_s = ZERO_W;
        if (state_r == ST_RUN) begin
            case (op_r)
                OP_HOLD:       begin j_s = ZERO_W;     k_s = ZERO_W;     end
                OP_CLEAR:      begin j_s = ZERO_W;     k_s = data_r;     end
                OP_SET:        begin j_s = data_r;     k_s = ZERO_W;     end
                OP_TOGGLE:     begin j_s = data_r;     k_s = data_r;     end
                OP_LOAD:       begin j_s = data_r;     k_s = ~data_r;    end
                OP_COUNT_UP:   begin j_s = carry_up_s; k_s = carry_up_s; end
                OP_COUNT_DOWN: begin j_s = carry_dn_s; k_s = carry_dn_s; end
                default:       begin j_s = ZERO_W;     k_s = ZERO_W;     end
            endcase
        end else begin
            j_s = ZERO_W;
            k_s = ZERO_W;
        end
    end

    // Sequencing FSM with registered status outputs
    always_ff @(posedge Clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_HOLD;
            data_r      <= ZERO_W;
            remaining_r <= ZERO_C;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (cmd_valid) begin
                        op_r        <= cmd_op;
                        data_r      <= cmd_data;
                        remaining_r <= (cmd_len == ZERO_C) ? ONE_C : cmd_len;
                        state_r     <= ST_RUN;
                        ready_r     <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    remaining_r <= remaining_r - ONE_C;
                    if (remaining_r == ONE_C) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            jk_cell u_cell (
                .Clk (Clk),
                .rst (rst),
                .J   (j_s[gi]),
                .K   (k_s[gi]),
                .Q   (q_s[gi])
            );
        end
    endgenerate

    // Ready is masked during reset so nothing is offered while the bank clears
    assign cmd_ready = ready_r & ~rst;
    assign busy      = busy_r;
    assign done      = done_r;
    assign Q         = q_s;

endmodule

// File: tb/tb_jk_bank_seq_ctrl.sv
// Directed self-checking bench for jk_bank_seq_ctrl (WIDTH=4, CNT_W=8).
module tb_jk_bank_seq_ctrl;

    logic       Clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_len;
    logic [3:0] Q;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    jk_bank_seq_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
        .Clk       (Clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .Q         (Q),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Waits (bounded) for ready, presents one command for one edge, then scrambles inputs
    task automatic send_cmd(input logic [2:0] op, input logic [3:0] data, input logic [7:0] len);
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_ready: cmd_ready=%b expected 1", cmd_ready);
        end
        cmd_op = op; cmd_data = data; cmd_len = len; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd_op = ~op; cmd_data = ~data; cmd_len = 8'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'h0; cmd_len = 8'd0;
        tick(); tick();
        checks++; if (Q !== 4'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", Q); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_load();
        send_cmd(3'd4, 4'hA, 8'd1);
        checks++; if (Q !== 4'h0) begin errors++; $display("FAIL load_accept_q: got %h expected 0", Q); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL load_accept_busy: got %b expected 1", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL load_accept_ready: got %b expected 0", cmd_ready); end
        tick();
        checks++; if (Q !== 4'hA) begin errors++; $display("FAIL load_q: got %h expected a", Q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL load_done: got %b expected 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL load_busy: got %b expected 0", busy); end
        tick();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL load_ready_back: got %b expected 1", cmd_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL load_done_drop: got %b expected 0", done); end
    endtask

    task automatic test_count_up_wrap();
        logic [3:0] exp_seq [7];
        int busy_cnt;
        exp_seq = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        busy_cnt = 0;
        send_cmd(3'd5, 4'h0, 8'd7);
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if (Q !== exp_seq[i]) begin errors++; $display("FAIL count_up_step%0d: got %h expected %h", i, Q, exp_seq[i]); end
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL count_up_done: got %b expected 1", done); end
        tick();
        if (busy === 1'b1) busy_cnt++;
        checks++; if (busy_cnt != 7) begin errors++; $display("FAIL count_up_busy_len: got %0d expected 7", busy_cnt); end
    endtask

    task automatic test_toggle_clear_down();
        send_cmd(3'd3, 4'h5, 8'd2);
        tick();
        checks++; if (Q !== 4'h4) begin errors++; $display("FAIL toggle_edge1: got %h expected 4", Q); end
        tick();
        checks++; if (Q !== 4'h1) begin errors++; $display("FAIL toggle_edge2: got %h expected 1", Q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL toggle_done: got %b expected 1", done); end
        send_cmd(3'd1, 4'hF, 8'd0);
        tick();
        checks++; if (Q !== 4'h0) begin errors++; $display("FAIL clear_len0_q: got %h expected 0", Q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clear_len0_done: got %b expected 1", done); end
        send_cmd(3'd6, 4'h0, 8'd1);
        tick();
        checks++; if (Q !== 4'hF) begin errors++; $display("FAIL count_down_wrap: got %h expected f", Q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL count_down_done: got %b expected 1", done); end
    endtask

    task automatic test_set_ignored();
        send_cmd(3'd1, 4'hF, 8'd1);
        tick();
        send_cmd(3'd2, 4'h6, 8'd3);
        tick();
        checks++; if (Q !== 4'h6) begin errors++; $display("FAIL set_edge1: got %h expected 6", Q); end
        cmd_op = 3'd4; cmd_data = 4'h9; cmd_len = 8'd1; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++; if (Q !== 4'h6) begin errors++; $display("FAIL set_edge2: got %h expected 6", Q); end
        tick();
        checks++; if (Q !== 4'h6) begin errors++; $display("FAIL set_at_done: got %h expected 6", Q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL set_done: got %b expected 1", done); end
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_not_queued: busy=%b expected 0", busy); end
        checks++; if (Q !== 4'h6) begin errors++; $display("FAIL ignored_q: got %h expected 6", Q); end
    endtask

    task automatic test_reset_mid_run();
        int done_cnt;
        int busy_cnt;
        send_cmd(3'd1, 4'hF, 8'd1);
        tick();
        send_cmd(3'd5, 4'h0, 8'd10);
        tick(); tick(); tick(); tick();
        checks++; if (Q !== 4'h4) begin errors++; $display("FAIL mid_run_q: got %h expected 4", Q); end
        rst = 1'b1;
        tick();
        checks++; if (Q !== 4'h0) begin errors++; $display("FAIL abort_q: got %h expected 0", Q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %b expected 0", cmd_ready); end
        rst = 1'b0;
        #1;
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: cmd_ready=%b expected 1", cmd_ready); end
        done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done === 1'b1) done_cnt++;
            if (busy === 1'b1) busy_cnt++;
        end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL abort_no_busy: got %0d cycles expected 0", busy_cnt); end
        send_cmd(3'd4, 4'h3, 8'd1);
        tick();
        checks++; if (Q !== 4'h3) begin errors++; $display("FAIL after_abort_load: got %h expected 3", Q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL after_abort_done: got %b expected 1", done); end
        tick();
    endtask

    task automatic test_reserved();
        int busy_cnt;
        int done_cnt;
        busy_cnt = 0; done_cnt = 0;
        send_cmd(3'd7, 4'hF, 8'd3);
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
        end
        checks++; if (Q !== 4'h3) begin errors++; $display("FAIL rsvd_q: got %h expected 3", Q); end
        checks++; if (busy_cnt != 3) begin errors++; $display("FAIL rsvd_busy_len: got %0d expected 3", busy_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rsvd_done_pulses: got %0d expected 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_count_up_wrap();
        test_toggle_clear_down();
        test_set_ignored();
        test_reset_mid_run();
        test_reserved();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
